apb_alu_requester: RTL and testbench
====================================

# apb_alu_requester

APB initiator that drives the ALU control-status register block from a simple valid/ready command port. Each accepted command becomes a fixed APB sequence: write operand 0, write operand 1, write CTRL with the start bit, poll STATUS until a result is available, then read RES. The block sits between a test/host command source and the CSR slave. It returns the 25-bit result word, or an error flag, on a valid/ready result port.

## Interface
Parameters:
- `REG_NUMBER`, 5, number of CSR registers; `paddr` width is `$clog2(REG_NUMBER)`.
- `REG_CTRL`, 0; `REG_0`, 1; `REG_1`, 2; `REG_RES`, 3; `REG_STATUS`, 4: register indices.
- `OPERATION_BIT`, 1; `OPERATION_SIZE`, 2: op field position and width in CTRL.
- `ID_BIT`, 8; `ID_SIZE`, 8: id field position and width in CTRL.
- `DATA_SIZE`, 16: operand width.
- `FIFO_OUT_WIDTH`, 25: result width.
- `APB_BUS_SIZE`, 32: APB data width.
- `POLL_MAX`, 255: maximum STATUS reads per command before timeout.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1; `cmd_ready`  out  1: command handshake.
- `cmd_op`  in  `OPERATION_SIZE`; `cmd_id`  in  `ID_SIZE`; `cmd_data0`, `cmd_data1`  in  `DATA_SIZE` each: command fields.
- `res_valid`  out  1; `res_ready`  in  1: result handshake.
- `res_data`  out  `FIFO_OUT_WIDTH`: RES read value. `res_err`  out  1: slave error or poll timeout.
- `paddr`  out  `$clog2(REG_NUMBER)`; `psel`, `penable`, `pwrite`  out  1 each; `pwdata`  out  `APB_BUS_SIZE`.
- `prdata`  in  `APB_BUS_SIZE`; `pready`, `pslverr`  in  1 each.

## Operation
- Reset values:
  - `cmd_ready`=1; `res_valid`=0; `res_err`=0; `res_data`=0.
  - `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0.
  - Poll counter=0; FSM in IDLE.
- Command accept: on `cmd_valid && cmd_ready` at an edge, latch all fields, drop `cmd_ready`, and start the step sequence. `cmd_ready` stays 0 until the result handshake completes.
- Step sequence:
  - W0: write `REG_0`, `pwdata` = zero-extended `data0`.
  - W1: write `REG_1`, `pwdata` = zero-extended `data1`.
  - WC: write `REG_CTRL`, `pwdata` = bit0 start=1, `[OPERATION_BIT+:OPERATION_SIZE]`=op, `[ID_BIT+:ID_SIZE]`=id, all other bits 0.
  - POLL: read `REG_STATUS`. `prdata[0]`=1 means result FIFO empty.
  - RD: read `REG_RES`, `res_data` = `prdata[FIFO_OUT_WIDTH-1:0]`.
- POLL handling:
  - If `prdata[0]`=1 and polls < `POLL_MAX`: increment the counter and repeat POLL.
  - If `prdata[0]`=0: go to RD.
  - If `POLL_MAX` polls all return empty: finish with `res_err`=1, `res_data`=0.
- FSM states: IDLE → SETUP → ACCESS → GAP → SETUP (next step) … → DONE → IDLE.
  - SETUP: `psel`=1, `penable`=0, address, direction and data stable.
  - ACCESS: `psel`=1, `penable`=1. Held until `pready`=1, with all signals stable while waiting.
  - GAP: `psel`=0, `penable`=0, one cycle between transfers.
  - DONE: `res_valid`=1, held with `res_data`/`res_err` stable until `res_ready`. On handshake: `res_valid`=0, `cmd_ready`=1, go to IDLE.
- Errors: `pslverr`=1 in the `pready` cycle of any transfer aborts the remaining steps. The block then enters DONE with `res_err`=1 and `res_data`=0. A result read is never issued after an error.
- Asserting `rst_n` mid-transfer immediately drops `psel`/`penable`. The command in flight is discarded and no result is produced.

## Timing
- Cycle 0 is the cmd handshake edge. With `pready` always 1 and the first poll non-empty:
  - SETUPs at cycles 1, 4, 7, 10, 13.
  - ACCESSes at cycles 2, 5, 8, 11, 14.
  - `res_valid`=1 from cycle 15.
- Each wait-state cycle (`pready`=0) adds one cycle. Each extra empty poll adds 3 cycles.
- `res_data` is registered from `prdata` at the RD `pready` edge.
- Minimum command-to-command spacing: 16 cycles. Back-to-back commands require `res_ready`=1 at cycle 15.

## Structure
- Shared package `apb_csr_pkg`:
  - register index constants;
  - CTRL field positions (start bit 0, op, id);
  - STATUS empty bit 0;
  - step enumeration W0/W1/WC/POLL/RD.
- One sub-module, `apb_master_port`, owns the SETUP/ACCESS/GAP handshake.
  - Inputs: `req`, `addr`, `write`, `wdata`.
  - Outputs: `done` pulse, `rdata`, `err`.
- The top level owns the step sequencing, poll counter and result port.

## Test plan
- op=1, id=0x5A, data0=0x0003, data1=0x0004, `pready`=1, first STATUS=0 → exactly 5 transfers, in order:
  - write addr1 0x3;
  - write addr2 0x4;
  - write addr0 0x5A03;
  - read addr4;
  - read addr3.
  - Then RES `prdata`=0x0000007 → `res_data`=0x000007 at cycle 15, `res_err`=0.
- STATUS returns 1 three times, then 0 → 4 polls, `res_valid` at cycle 24.
- `POLL_MAX`=4, STATUS always 1 → 4 polls, then `res_err`=1, `res_data`=0, and no read of addr3.
- `pslverr`=1 on the CTRL write → no further transfers; `res_err`=1; `cmd_ready` returns after `res_ready`.
- `pready`=0 for 3 cycles on the W1 access → `psel`, `penable`, `paddr`, `pwdata` stable throughout; result is 3 cycles later than the no-wait case.
- `rst_n` low during the POLL access → `psel`=0 in the same cycle, `cmd_ready`=1 after release, no `res_valid`.

Source files
------------

// File: rtl/apb_csr_pkg.sv
// Shared definitions for the ALU CSR block and its APB requester:
// register map, CTRL/STATUS field positions and sequencing enums.
package apb_csr_pkg;

  localparam int CSR_CTRL   = 0;
  localparam int CSR_OP0    = 1;
  localparam int CSR_OP1    = 2;
  localparam int CSR_RES    = 3;
  localparam int CSR_STATUS = 4;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_OP_BIT    = 1;
  localparam int CTRL_OP_SIZE   = 2;
  localparam int CTRL_ID_BIT    = 8;
  localparam int CTRL_ID_SIZE   = 8;

  localparam int STATUS_EMPTY_BIT = 0;

  typedef enum logic [2:0] {
    STEP_W0,
    STEP_W1,
    STEP_WC,
    STEP_POLL,
    STEP_RD
  } step_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SETUP,
    P_ACCESS,
    P_GAP
  } pstate_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_WAIT,
    T_ISSUE,
    T_DONE
  } tstate_e;

endpackage

// File: rtl/apb_master_port.sv
// APB transfer engine: one request becomes SETUP, ACCESS (held
// until pready) and a one-cycle GAP; a new request may start in GAP.
module apb_master_port
  import apb_csr_pkg::*;
#(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic          write,
  input  logic [DW-1:0] wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [AW-1:0] paddr,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  pstate_e       state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [DW-1:0] wdata_q;
  logic          accept;

  assign accept = req &&
                  (state_q == P_IDLE || state_q == P_GAP);

  // Transfer phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= P_IDLE;
    else        state_q <= state_d;
  end

  // Address/direction/data held stable from SETUP through ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= addr;
      write_q <= write;
      wdata_q <= wdata;
    end
  end

  // Phase sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      P_IDLE,
      P_GAP:    state_d = req ? P_SETUP : P_IDLE;
      P_SETUP:  state_d = P_ACCESS;
      P_ACCESS: if (pready) state_d = P_GAP;
      default:  state_d = P_IDLE;
    endcase
  end

  // Bus strobes and completion reporting
  always_comb begin
    psel    = (state_q == P_SETUP) ||
              (state_q == P_ACCESS);
    penable = (state_q == P_ACCESS);
    done    = (state_q == P_ACCESS) && pready;
    err     = done && pslverr;
    rdata   = prdata;
    paddr   = addr_q;
    pwrite  = write_q;
    pwdata  = wdata_q;
  end

endmodule

// File: rtl/apb_alu_requester.sv
// Command-to-APB sequencer for the ALU CSR block: writes operands and
// CTRL, polls STATUS, reads RES and returns it on a result handshake.
module apb_alu_requester
  import apb_csr_pkg::*;
#(
  parameter int REG_NUMBER     = 5,
  parameter int REG_CTRL       = CSR_CTRL,
  parameter int REG_0          = CSR_OP0,
  parameter int REG_1          = CSR_OP1,
  parameter int REG_RES        = CSR_RES,
  parameter int REG_STATUS     = CSR_STATUS,
  parameter int OPERATION_BIT  = CTRL_OP_BIT,
  parameter int OPERATION_SIZE = CTRL_OP_SIZE,
  parameter int ID_BIT         = CTRL_ID_BIT,
  parameter int ID_SIZE        = CTRL_ID_SIZE,
  parameter int DATA_SIZE      = 16,
  parameter int FIFO_OUT_WIDTH = 25,
  parameter int APB_BUS_SIZE   = 32,
  parameter int POLL_MAX       = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [OPERATION_SIZE-1:0]     cmd_op,
  input  logic [ID_SIZE-1:0]            cmd_id,
  input  logic [DATA_SIZE-1:0]          cmd_data0,
  input  logic [DATA_SIZE-1:0]          cmd_data1,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [FIFO_OUT_WIDTH-1:0]     res_data,
  output logic                          res_err,
  output logic [$clog2(REG_NUMBER)-1:0] paddr,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [APB_BUS_SIZE-1:0]       pwdata,
  input  logic [APB_BUS_SIZE-1:0]       prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int AW  = $clog2(REG_NUMBER);
  localparam int PCW = $clog2(POLL_MAX + 1);

  tstate_e                   state_q, state_d;
  step_e                     step_q, step_d;
  logic [PCW-1:0]            poll_q, poll_d;
  logic [FIFO_OUT_WIDTH-1:0] res_data_q, res_data_d;
  logic                      res_err_q, res_err_d;

  logic [OPERATION_SIZE-1:0] op_q;
  logic [ID_SIZE-1:0]        id_q;
  logic [DATA_SIZE-1:0]      d0_q, d1_q;

  logic                      prt_req;
  logic [AW-1:0]             prt_addr;
  logic                      prt_write;
  logic [APB_BUS_SIZE-1:0]   prt_wdata;
  logic                      prt_done;
  logic [APB_BUS_SIZE-1:0]   prt_rdata;
  logic                      prt_err;

  logic                      accept;
  logic                      poll_empty;
  logic                      poll_more;
  logic [APB_BUS_SIZE-1:0]   ctrl_word;
  logic                      unused_rdata;

  assign accept     = (state_q == T_IDLE) && cmd_valid;
  assign poll_empty = prt_rdata[STATUS_EMPTY_BIT];
  assign poll_more  = (int'(poll_q) + 1) < POLL_MAX;
  assign unused_rdata =
    ^prt_rdata[APB_BUS_SIZE-1:FIFO_OUT_WIDTH];

  // CTRL word: start bit plus op and id fields, all else zero
  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_START_BIT] = 1'b1;
    ctrl_word[OPERATION_BIT +: OPERATION_SIZE] = op_q;
    ctrl_word[ID_BIT +: ID_SIZE] = id_q;
  end

  // Sequencer state, step, poll count and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= T_IDLE;
      step_q     <= STEP_W0;
      poll_q     <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      poll_q     <= poll_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  // Command fields captured at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      id_q <= '0;
      d0_q <= '0;
      d1_q <= '0;
    end else if (accept) begin
      op_q <= cmd_op;
      id_q <= cmd_id;
      d0_q <= cmd_data0;
      d1_q <= cmd_data1;
    end
  end

  // Step sequencing, poll decisions and result capture
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    poll_d     = poll_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    unique case (state_q)
      T_IDLE: begin
        if (cmd_valid) begin
          state_d    = T_WAIT;
          step_d     = STEP_W0;
          poll_d     = '0;
          res_data_d = '0;
          res_err_d  = 1'b0;
        end
      end
      T_ISSUE: state_d = T_WAIT;
      T_WAIT: begin
        if (prt_done && prt_err) begin
          state_d    = T_DONE;
          res_data_d = '0;
          res_err_d  = 1'b1;
        end else if (prt_done) begin
          state_d = T_ISSUE;
          unique case (step_q)
            STEP_W0: step_d = STEP_W1;
            STEP_W1: step_d = STEP_WC;
            STEP_WC: begin
              step_d = STEP_POLL;
              poll_d = '0;
            end
            STEP_POLL: begin
              if (!poll_empty) begin
                step_d = STEP_RD;
              end else if (poll_more) begin
                poll_d = poll_q + 1'b1;
              end else begin
                state_d    = T_DONE;
                res_data_d = '0;
                res_err_d  = 1'b1;
              end
            end
            STEP_RD: begin
              state_d    = T_DONE;
              res_data_d = prt_rdata[FIFO_OUT_WIDTH-1:0];
            end
            default: state_d = T_DONE;
          endcase
        end
      end
      T_DONE: if (res_ready) state_d = T_IDLE;
      default: state_d = T_IDLE;
    endcase
  end

  // Handshake outputs and the transfer request for the current step
  always_comb begin
    cmd_ready = (state_q == T_IDLE);
    res_valid = (state_q == T_DONE);
    res_data  = res_data_q;
    res_err   = res_err_q;
    prt_req   = (state_q == T_ISSUE);
    prt_addr  = AW'(REG_0);
    prt_write = 1'b1;
    prt_wdata = APB_BUS_SIZE'(d0_q);
    unique case (step_q)
      STEP_W0: begin
        prt_addr  = AW'(REG_0);
        prt_wdata = APB_BUS_SIZE'(d0_q);
      end
      STEP_W1: begin
        prt_addr  = AW'(REG_1);
        prt_wdata = APB_BUS_SIZE'(d1_q);
      end
      STEP_WC: begin
        prt_addr  = AW'(REG_CTRL);
        prt_wdata = ctrl_word;
      end
      STEP_POLL: begin
        prt_addr  = AW'(REG_STATUS);
        prt_write = 1'b0;
        prt_wdata = '0;
      end
      STEP_RD: begin
        prt_addr  = AW'(REG_RES);
        prt_write = 1'b0;
        prt_wdata = '0;
      end
      default: ;
    endcase
    if (state_q == T_IDLE) begin
      prt_req   = cmd_valid;
      prt_addr  = AW'(REG_0);
      prt_write = 1'b1;
      prt_wdata = APB_BUS_SIZE'(cmd_data0);
    end
  end

  apb_master_port #(
    .AW (AW),
    .DW (APB_BUS_SIZE)
  ) u_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (prt_req),
    .addr    (prt_addr),
    .write   (prt_write),
    .wdata   (prt_wdata),
    .done    (prt_done),
    .rdata   (prt_rdata),
    .err     (prt_err),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

endmodule

// File: tb/tb_apb_alu_requester.sv
// Randomized scoreboard bench for apb_alu_requester with a
// behavioural CSR slave and a transaction-level reference model.
module tb_apb_alu_requester;

  localparam int PMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_id;
  logic [15:0] cmd_data0, cmd_data1;
  logic        res_valid, res_ready;
  logic [24:0] res_data;
  logic        res_err;
  logic [2:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  always #5 clk = ~clk;

  apb_alu_requester #(.POLL_MAX(PMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_id    (cmd_id),
    .cmd_data0 (cmd_data0),
    .cmd_data1 (cmd_data1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  typedef struct {
    int          n_empty;
    int          err_idx;
    int          wait_idx;
    int          wait_n;
    logic [1:0]  op;
    logic [7:0]  id;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [24:0] rv;
  } cfg_t;

  typedef struct {
    logic [2:0]  a;
    logic        w;
    logic [31:0] d;
  } xf_t;

  typedef struct {
    logic        e;
    logic [24:0] d;
    int          cyc;
  } rs_t;

  xf_t  xq[$];
  rs_t  rq[$];
  cfg_t cfg;
  int   xidx = 0;
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   rr_mode = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    fails++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // Behavioural CSR slave with wait states, errors and STATUS script
  logic [2:0]  ca;
  logic        cw;
  logic [31:0] cd;
  int          wl, cur;
  logic [31:0] tmp;
  xf_t         xr;
  always @(negedge clk) begin
    if (!rst_n) begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end else if (psel && !penable) begin
      ca = paddr; cw = pwrite; cd = pwdata;
      cur = xidx;
      xidx++;
      wl = (cur == cfg.wait_idx) ? cfg.wait_n : 0;
      pready  = 1'b0;
      pslverr = 1'b0;
    end else if (psel && penable) begin
      chk("apb_stable", {paddr, pwrite, pwdata}, {ca, cw, cd});
      if (wl > 0) begin
        wl--;
        pready = 1'b0;
      end else begin
        pready  = 1'b1;
        pslverr = (cur == cfg.err_idx);
        tmp = $urandom();
        if (paddr == 3'd4) tmp[0] = ((cur - 3) < cfg.n_empty);
        if (paddr == 3'd3) tmp[24:0] = cfg.rv;
        prdata = tmp;
        if (xq.size() == 0) begin
          bad("unexpected_xfer");
        end else begin
          xr = xq.pop_front();
          chk("xfer_addr", paddr, xr.a);
          chk("xfer_dir", pwrite, xr.w);
          if (xr.w) chk("xfer_wdata", pwdata, xr.d);
        end
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  // Result monitor: latency, stability, payload and cmd_ready return
  bit          prev_rv = 1'b0;
  bit          chk_cr = 1'b0;
  logic [24:0] hd;
  logic        he;
  rs_t         rr;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv   = 1'b0;
      chk_cr    = 1'b0;
      res_ready = 1'b0;
    end else begin
      if (chk_cr) begin
        chk("cmd_ready_after_result", cmd_ready, 1);
        chk_cr = 1'b0;
      end
      res_ready = rr_mode ? 1'b1 : 1'($urandom_range(0, 1));
      if (res_valid) begin
        if (!prev_rv) begin
          if (rq.size() == 0) bad("unexpected_result");
          else chk("res_latency", cyc, rq[0].cyc);
          hd = res_data;
          he = res_err;
        end else begin
          chk("res_stable", {res_data, res_err}, {hd, he});
        end
        if (res_ready) begin
          if (rq.size() != 0) begin
            rr = rq.pop_front();
            chk("res_err", res_err, rr.e);
            chk("res_data", res_data, rr.d);
            chk("xfers_left", xq.size(), 0);
          end
          chk_cr  = 1'b1;
          prev_rv = 1'b0;
        end else begin
          prev_rv = 1'b1;
        end
      end else begin
        prev_rv = 1'b0;
      end
    end
  end

  // Reference model plus command drive; returns the handshake edge
  task automatic issue(input cfg_t c, output int hs);
    xf_t xl[$];
    bit  e;
    int  np, n, w;
    hs = -1;
    for (int i = 0; i < 400 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) begin
      bad("cmd_ready_timeout");
      return;
    end
    cfg  = c;
    xidx = 0;
    xl.push_back('{3'd1, 1'b1, 32'(c.d0)});
    xl.push_back('{3'd2, 1'b1, 32'(c.d1)});
    xl.push_back('{3'd0, 1'b1,
                   32'(1 + int'(c.op) * 2 + int'(c.id) * 256)});
    e  = (c.n_empty >= PMAX);
    np = e ? PMAX : c.n_empty + 1;
    for (int i = 0; i < np; i++) xl.push_back('{3'd4, 1'b0, 32'd0});
    if (!e) xl.push_back('{3'd3, 1'b0, 32'd0});
    if (c.err_idx >= 0 && c.err_idx < xl.size()) begin
      while (xl.size() > c.err_idx + 1) void'(xl.pop_back());
      e = 1'b1;
    end
    n  = xl.size();
    w  = (c.wait_idx >= 0 && c.wait_idx < n) ? c.wait_n : 0;
    hs = cyc + 1;
    foreach (xl[i]) xq.push_back(xl[i]);
    rq.push_back('{e, e ? 25'd0 : c.rv, hs + 3 * n + w - 1});
    cmd_op    = c.op;
    cmd_id    = c.id;
    cmd_data0 = c.d0;
    cmd_data1 = c.d1;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (rq.size() == 0 && cmd_ready) break;
      @(negedge clk);
    end
    if (i == 3000) bad("drain_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_t c;
    int   h1, h2;
    bit   seen;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_id = '0;
    cmd_data0 = '0; cmd_data1 = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    res_ready = 1'b0;
    cfg = '{0, -1, -1, 0, 2'd0, 8'd0, 16'd0, 16'd0, 25'd0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);

    rr_mode = 1'b1;
    c = '{0, -1, -1, 0, 2'd1, 8'h5A, 16'h3, 16'h4, 25'h7};
    issue(c, h1);
    c = '{3, -1, -1, 0, 2'd2, 8'h11, 16'hBEEF, 16'h1234, 25'h1ABCDEF};
    issue(c, h2);
    chk("b2b_spacing", h2 - h1, 16);
    drain();
    c = '{9, -1, -1, 0, 2'd3, 8'h22, 16'h5, 16'h6, 25'h55};
    issue(c, h1);
    drain();
    c = '{0, 2, -1, 0, 2'd0, 8'h33, 16'h7, 16'h8, 25'h66};
    issue(c, h1);
    drain();
    c = '{0, -1, 1, 3, 2'd1, 8'h44, 16'h9, 16'hA, 25'h77};
    issue(c, h1);
    drain();

    c = '{3, -1, -1, 0, 2'd2, 8'h55, 16'hB, 16'hC, 25'h88};
    issue(c, h1);
    for (int i = 0; i < 100; i++) begin
      if (psel && penable && paddr == 3'd4) break;
      @(negedge clk);
    end
    chk("reach_poll", {psel, penable, paddr}, {1'b1, 1'b1, 3'd4});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_psel", psel, 0);
    chk("rst_mid_penable", penable, 0);
    xq.delete();
    rq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("rst_mid_no_result", seen, 0);

    rr_mode = 1'b0;
    repeat (40) begin
      c.n_empty  = $urandom_range(0, 5);
      c.err_idx  = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(0, 8)) : -1;
      c.wait_idx = ($urandom_range(0, 1) == 0) ?
                   int'($urandom_range(0, 8)) : -1;
      c.wait_n   = $urandom_range(1, 3);
      c.op       = 2'($urandom());
      c.id       = 8'($urandom());
      c.d0       = 16'($urandom());
      c.d1       = 16'($urandom());
      c.rv       = 25'($urandom());
      issue(c, h1);
    end
    drain();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
